clock_gate_controller_v2: RTL and testbench

Second-generation per-domain clock-gate controller for the power-management subsystem. Drives enables for external integrated clock-gating (ICG) cells; it never outputs a clock. Adds a sliding activity window, an idle timeout, a drain/ack handshake before gating, a timed wake sequence with clock-valid qualification, and a saturating power-savings estimate.

---
 rtl/clock_gate_controller_v2_pkg.sv | 16 +
 rtl/clock_gate_controller_v2_if.sv | 22 ++
 rtl/clock_gate_controller_v2_domain_gate_fsm.sv | 115 +++++++++++
 rtl/clock_gate_controller_v2.sv | 90 +++++++++
 tb/tb_clock_gate_controller_v2.sv | 305 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/clock_gate_controller_v2_pkg.sv
// Shared types and constants for the per-domain clock-gate controller.
package power_mgmt_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        OFF   = 2'd2,
        WAKE  = 2'd3
    } gate_state_t;

    localparam logic [1:0] PM_ALWAYS_ON = 2'd0;
    localparam logic [1:0] PM_WINDOW    = 2'd1;
    localparam logic [1:0] PM_IDLE      = 2'd2;
    localparam logic [1:0] PM_FORCE_OFF = 2'd3;

endpackage

// File: rtl/clock_gate_controller_v2_if.sv
// Per-domain handshake bundle between the gate controller and its clock domains.
interface clock_gate_controller_v2_if #(
    parameter int unsigned NUM_DOMAINS = 16
) ();
    logic [NUM_DOMAINS-1:0] domain_enable;
    logic [NUM_DOMAINS-1:0] activity_detect;
    logic [NUM_DOMAINS-1:0] wake_req;
    logic [NUM_DOMAINS-1:0] drain_ack;
    logic [NUM_DOMAINS-1:0] drain_req;
    logic [NUM_DOMAINS-1:0] clk_en;
    logic [NUM_DOMAINS-1:0] clock_valid;

    modport master (
        input  domain_enable, activity_detect, wake_req, drain_ack,
        output drain_req, clk_en, clock_valid
    );

    modport slave (
        output domain_enable, activity_detect, wake_req, drain_ack,
        input  drain_req, clk_en, clock_valid
    );
endinterface

// File: rtl/clock_gate_controller_v2_domain_gate_fsm.sv
// One domain's gating FSM with its activity window, idle counter and wake timer.
module domain_gate_fsm
    import power_mgmt_pkg::*;
#(
    parameter int unsigned WIN_DEPTH   = 8,
    parameter int unsigned IDLE_W      = 16,
    parameter int unsigned WAKE_CYCLES = 4
) (
    input  logic                             ref_clk,
    input  logic                             rst_n,
    input  logic                             domain_enable,
    input  logic                             activity_detect,
    input  logic                             wake_req,
    input  logic                             drain_ack,
    input  logic [1:0]                       power_mode,
    input  logic [$clog2(WIN_DEPTH+1)-1:0]   act_threshold,
    input  logic [IDLE_W-1:0]                idle_limit,
    output logic                             drain_req,
    output logic                             clk_en,
    output logic                             clock_valid,
    output logic                             off
);
    localparam int unsigned SUM_W = $clog2(WIN_DEPTH + 1);
    localparam int unsigned WK_W  = (WAKE_CYCLES > 1) ? $clog2(WAKE_CYCLES) : 1;
    localparam logic [SUM_W-1:0] FILL_FULL = SUM_W'(WIN_DEPTH);
    localparam logic [WK_W-1:0]  WAKE_LAST = WK_W'(WAKE_CYCLES - 1);

    gate_state_t          st_q, st_d;
    logic [WIN_DEPTH-1:0] win_q, win_d;
    logic [SUM_W-1:0]     sum_q, sum_d;
    logic [SUM_W-1:0]     fill_q, fill_d;
    logic [IDLE_W-1:0]    idle_q, idle_d;
    logic [WK_W-1:0]      wk_q, wk_d;
    logic                 gate_cond, wake_cond, run_entry;

    always_comb begin
        gate_cond = 1'b0;
        case (power_mode)
            PM_ALWAYS_ON: gate_cond = 1'b0;
            PM_WINDOW:    gate_cond = (fill_q == FILL_FULL) && (sum_q < act_threshold);
            PM_IDLE:      gate_cond = (idle_q >= idle_limit);
            PM_FORCE_OFF: gate_cond = 1'b1;
            default:      gate_cond = 1'b0;
        endcase
        if (!domain_enable) gate_cond = 1'b1;

        wake_cond = domain_enable && (power_mode != PM_FORCE_OFF) &&
                    ((power_mode == PM_ALWAYS_ON) || wake_req || activity_detect);
    end

    always_comb begin
        st_d = st_q;
        wk_d = wk_q;
        case (st_q)
            RUN: if (gate_cond) st_d = DRAIN;
            // Abort beats ack: the domain stays clocked if gating no longer applies.
            DRAIN: begin
                if (!gate_cond || wake_req) st_d = RUN;
                else if (drain_ack)         st_d = OFF;
            end
            OFF: begin
                if (wake_cond) begin
                    st_d = WAKE;
                    wk_d = '0;
                end
            end
            WAKE: begin
                if (wk_q == WAKE_LAST) st_d = RUN;
                else                   wk_d = wk_q + WK_W'(1);
            end
            default: st_d = RUN;
        endcase
        run_entry = (st_d == RUN) && (st_q != RUN);
    end

    always_comb begin
        win_d = {win_q[WIN_DEPTH-2:0], activity_detect};
        sum_d = sum_q + SUM_W'(activity_detect) - SUM_W'(win_q[WIN_DEPTH-1]);

        if (run_entry)              fill_d = '0;
        else if (fill_q != FILL_FULL) fill_d = fill_q + SUM_W'(1);
        else                        fill_d = fill_q;

        if (run_entry || activity_detect) idle_d = '0;
        else if (idle_q != '1)            idle_d = idle_q + IDLE_W'(1);
        else                              idle_d = idle_q;
    end

    always_ff @(posedge ref_clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q        <= RUN;
            win_q       <= '0;
            sum_q       <= '0;
            fill_q      <= '0;
            idle_q      <= '0;
            wk_q        <= '0;
            drain_req   <= 1'b0;
            clk_en      <= 1'b1;
            clock_valid <= 1'b1;
        end else begin
            st_q        <= st_d;
            win_q       <= win_d;
            sum_q       <= sum_d;
            fill_q      <= fill_d;
            idle_q      <= idle_d;
            wk_q        <= wk_d;
            drain_req   <= (st_d == DRAIN);
            clk_en      <= (st_d != OFF);
            clock_valid <= (st_d == RUN) || (st_d == DRAIN);
        end
    end

    assign off = (st_q == OFF);

endmodule

// File: rtl/clock_gate_controller_v2.sv
// Clock-gate controller top: per-domain FSMs, gated-domain count and savings estimate.
// Optional CLOCK_GATE_STATS_EN adds stats_clear and the gated_cycles_total accumulator.
module clock_gate_controller_v2
    import power_mgmt_pkg::*;
#(
    parameter int unsigned NUM_DOMAINS = 16,
    parameter int unsigned WIN_DEPTH   = 8,
    parameter int unsigned IDLE_W      = 16,
    parameter int unsigned WAKE_CYCLES = 4,
    parameter int unsigned SAVE_WEIGHT = 100
) (
    input  logic                               ref_clk,
    input  logic                               rst_n,
    clock_gate_controller_v2_if.master         dom,
    input  logic [1:0]                         power_mode,
    input  logic [$clog2(WIN_DEPTH+1)-1:0]     act_threshold,
    input  logic [IDLE_W-1:0]                  idle_limit,
    output logic [$clog2(NUM_DOMAINS+1)-1:0]   gated_count,
    output logic [15:0]                        power_savings_estimate
`ifdef CLOCK_GATE_STATS_EN
    ,
    input  logic                               stats_clear,
    output logic [31:0]                        gated_cycles_total
`endif
);
    localparam int unsigned CNT_W = $clog2(NUM_DOMAINS + 1);

    logic [NUM_DOMAINS-1:0] drain_req_w, clk_en_w, valid_w, off_w;
    logic [CNT_W-1:0]       off_cnt;
    logic [31:0]            est_full;
    logic [15:0]            est_d;

    for (genvar i = 0; i < NUM_DOMAINS; i++) begin : g_dom
        domain_gate_fsm #(
            .WIN_DEPTH   (WIN_DEPTH),
            .IDLE_W      (IDLE_W),
            .WAKE_CYCLES (WAKE_CYCLES)
        ) u_fsm (
            .ref_clk         (ref_clk),
            .rst_n           (rst_n),
            .domain_enable   (dom.domain_enable[i]),
            .activity_detect (dom.activity_detect[i]),
            .wake_req        (dom.wake_req[i]),
            .drain_ack       (dom.drain_ack[i]),
            .power_mode      (power_mode),
            .act_threshold   (act_threshold),
            .idle_limit      (idle_limit),
            .drain_req       (drain_req_w[i]),
            .clk_en          (clk_en_w[i]),
            .clock_valid     (valid_w[i]),
            .off             (off_w[i])
        );
    end

    assign dom.drain_req   = drain_req_w;
    assign dom.clk_en      = clk_en_w;
    assign dom.clock_valid = valid_w;

    always_comb begin
        off_cnt = '0;
        for (int i = 0; i < NUM_DOMAINS; i++) off_cnt = off_cnt + CNT_W'(off_w[i]);
    end

    assign est_full = 32'(off_cnt) * 32'(SAVE_WEIGHT);
    assign est_d    = (est_full > 32'h0000_FFFF) ? 16'hFFFF : est_full[15:0];

    // Count and estimate are both taken from the same state snapshot.
    always_ff @(posedge ref_clk or negedge rst_n) begin
        if (!rst_n) begin
            gated_count            <= '0;
            power_savings_estimate <= '0;
        end else begin
            gated_count            <= off_cnt;
            power_savings_estimate <= est_d;
        end
    end

`ifdef CLOCK_GATE_STATS_EN
    logic [32:0] total_sum;
    assign total_sum = {1'b0, gated_cycles_total} + 33'(gated_count);

    always_ff @(posedge ref_clk or negedge rst_n) begin
        if (!rst_n)            gated_cycles_total <= '0;
        else if (stats_clear)  gated_cycles_total <= '0;
        else if (total_sum[32]) gated_cycles_total <= '1;
        else                   gated_cycles_total <= total_sum[31:0];
    end
`endif

endmodule

// File: tb/tb_clock_gate_controller_v2.sv
// Directed bench for clock_gate_controller_v2 with a cycle-level behavioural reference model.
module tb_clock_gate_controller_v2;
    localparam int ND = 16;
    localparam int WD = 8;
    localparam int WC = 4;
    localparam int SW = 100;
    localparam int IDLE_MAX = 65535;
    localparam int M_ON = 0, M_DRAINING = 1, M_GATED = 2, M_WAKING = 3;

    logic        ref_clk = 1'b0;
    logic        rst_n;
    logic [1:0]  power_mode;
    logic [3:0]  act_threshold;
    logic [15:0] idle_limit;
    logic [4:0]  gated_count;
    logic [15:0] power_savings_estimate;
`ifdef CLOCK_GATE_STATS_EN
    logic        stats_clear;
    logic [31:0] gated_cycles_total;
`endif

    clock_gate_controller_v2_if #(.NUM_DOMAINS(ND)) bus ();

    clock_gate_controller_v2 dut (
        .ref_clk                (ref_clk),
        .rst_n                  (rst_n),
        .dom                    (bus),
        .power_mode             (power_mode),
        .act_threshold          (act_threshold),
        .idle_limit             (idle_limit),
        .gated_count            (gated_count),
        .power_savings_estimate (power_savings_estimate)
`ifdef CLOCK_GATE_STATS_EN
        ,
        .stats_clear            (stats_clear),
        .gated_cycles_total     (gated_cycles_total)
`endif
    );

    always #5 ref_clk = ~ref_clk;

    int n_asserts = 0;
    int n_fail    = 0;

    // Reference model: phase per domain, recent activity history, idle and age counters.
    int              ph[ND];
    int              idle[ND];
    int              run_age[ND];
    int              wake_age[ND];
    logic [ND-1:0]   act_hist[$];
    int              exp_gc;
    longint          exp_total;

    int              dr_age[ND];
    logic [ND-1:0]   ack_mask;
    logic [ND-1:0]   man_ack;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_asserts++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < ND; d++) begin
            ph[d] = M_ON;
            idle[d] = 0;
            run_age[d] = 0;
            wake_age[d] = 0;
            dr_age[d] = 0;
        end
        act_hist.delete();
        exp_gc = 0;
        exp_total = 0;
    endtask

    task automatic model_step();
        int gc_before;
        int n_off;
        logic [ND-1:0] act;
        gc_before = exp_gc;
        n_off = 0;
        for (int d = 0; d < ND; d++) if (ph[d] == M_GATED) n_off++;
        act = bus.activity_detect;
        for (int d = 0; d < ND; d++) begin
            int s, nxt;
            bit en, gate, wake, entering;
            s = 0;
            foreach (act_hist[k]) s += int'(act_hist[k][d]);
            en = bus.domain_enable[d];
            gate = !en || power_mode == 2'd3 ||
                   (power_mode == 2'd1 && run_age[d] >= WD && s < int'(act_threshold)) ||
                   (power_mode == 2'd2 && idle[d] >= int'(idle_limit));
            wake = en && power_mode != 2'd3 &&
                   (power_mode == 2'd0 || bus.wake_req[d] || act[d]);
            nxt = ph[d];
            case (ph[d])
                M_ON: if (gate) nxt = M_DRAINING;
                M_DRAINING: begin
                    if (!gate || bus.wake_req[d]) nxt = M_ON;
                    else if (bus.drain_ack[d])    nxt = M_GATED;
                end
                M_GATED: if (wake) begin nxt = M_WAKING; wake_age[d] = 0; end
                default: begin
                    wake_age[d]++;
                    if (wake_age[d] >= WC) nxt = M_ON;
                end
            endcase
            entering = (nxt == M_ON) && (ph[d] != M_ON);
            if (entering || act[d])     idle[d] = 0;
            else if (idle[d] < IDLE_MAX) idle[d] = idle[d] + 1;
            run_age[d] = entering ? 0 : run_age[d] + 1;
            ph[d] = nxt;
        end
        act_hist.push_back(act);
        if (act_hist.size() > WD) void'(act_hist.pop_front());
        exp_gc = n_off;
`ifdef CLOCK_GATE_STATS_EN
        if (stats_clear) exp_total = 0;
        else begin
            exp_total = exp_total + gc_before;
            if (exp_total > 64'hFFFF_FFFF) exp_total = 64'hFFFF_FFFF;
        end
`else
        if (gc_before < 0) exp_total = 0;
`endif
    endtask

    task automatic compare_all();
        logic [ND-1:0] e_en, e_cv, e_dr;
        int est;
        for (int d = 0; d < ND; d++) begin
            e_en[d] = (ph[d] != M_GATED);
            e_cv[d] = (ph[d] == M_ON) || (ph[d] == M_DRAINING);
            e_dr[d] = (ph[d] == M_DRAINING);
        end
        est = exp_gc * SW;
        if (est > 65535) est = 65535;
        check("clk_en", 32'(bus.clk_en), 32'(e_en));
        check("clock_valid", 32'(bus.clock_valid), 32'(e_cv));
        check("drain_req", 32'(bus.drain_req), 32'(e_dr));
        check("gated_count", 32'(gated_count), 32'(exp_gc));
        check("estimate", 32'(power_savings_estimate), 32'(est));
`ifdef CLOCK_GATE_STATS_EN
        check("gated_cycles_total", gated_cycles_total, exp_total[31:0]);
`endif
    endtask

    task automatic step();
        logic [ND-1:0] auto_ack;
        @(posedge ref_clk);
        model_step();
        #1;
        compare_all();
        for (int d = 0; d < ND; d++) begin
            dr_age[d] = bus.drain_req[d] ? dr_age[d] + 1 : 0;
            auto_ack[d] = ack_mask[d] && (dr_age[d] >= 2);
        end
        bus.drain_ack = auto_ack | man_ack;
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("reset_clk_en", 32'(bus.clk_en), 32'h0000_FFFF);
        check("reset_clock_valid", 32'(bus.clock_valid), 32'h0000_FFFF);
        check("reset_drain_req", 32'(bus.drain_req), 32'h0);
        check("reset_gated_count", 32'(gated_count), 32'h0);
        check("reset_estimate", 32'(power_savings_estimate), 32'h0);
`ifdef CLOCK_GATE_STATS_EN
        check("reset_gated_cycles_total", gated_cycles_total, 32'h0);
`endif
        model_reset();
        bus.drain_ack = '0;
        #2 rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b1;
        power_mode = 2'd0;
        act_threshold = 4'd3;
        idle_limit = 16'd10;
        bus.domain_enable = '1;
        bus.activity_detect = '1;
        bus.wake_req = '0;
        bus.drain_ack = '0;
        ack_mask = '0;
        man_ack = '0;
`ifdef CLOCK_GATE_STATS_EN
        stats_clear = 1'b0;
`endif
        model_reset();
        #1 do_reset();

        // Always-on: everything clocked.
        run(6);
        check("mode0_clk_en", 32'(bus.clk_en), 32'h0000_FFFF);
        check("mode0_clock_valid", 32'(bus.clock_valid), 32'h0000_FFFF);
        check("mode0_estimate", 32'(power_savings_estimate), 32'h0);

        // Window mode: domain 2 active 2 of 8 cycles, others always active.
        power_mode = 2'd1;
        ack_mask = 16'h0004;
        for (int i = 0; i < 14; i++) begin
            bus.activity_detect[2] = ((i % 8) < 2);
            step();
            if (i == 7)  check("win_no_drain_yet", 32'(bus.drain_req[2]), 32'h0);
            if (i == 8)  check("win_drain_req", 32'(bus.drain_req[2]), 32'h1);
            if (i == 9)  check("win_clk_en_before_ack", 32'(bus.clk_en[2]), 32'h1);
            if (i == 10) check("win_clk_en_after_ack", 32'(bus.clk_en[2]), 32'h0);
        end
        bus.activity_detect[2] = 1'b0;
        run(3);
        check("win_clk_en", 32'(bus.clk_en), 32'h0000_FFFB);
        check("win_gated_count", 32'(gated_count), 32'h1);
        check("win_estimate", 32'(power_savings_estimate), 32'd100);

        // Mid-operation reset with domain 2 gated, then idle-timeout mode.
        do_reset();
        power_mode = 2'd2;
        ack_mask = 16'h0020;
        bus.activity_detect = ~16'h0020;
        for (int j = 1; j <= 15; j++) begin
            step();
            if (j == 10) check("idle_no_drain_yet", 32'(bus.drain_req[5]), 32'h0);
            if (j == 11) check("idle_drain_req", 32'(bus.drain_req[5]), 32'h1);
        end
        check("idle_clk_en_off", 32'(bus.clk_en[5]), 32'h0);
        bus.wake_req[5] = 1'b1;
        step();
        check("wake_clk_en", 32'(bus.clk_en[5]), 32'h1);
        check("wake_not_valid", 32'(bus.clock_valid[5]), 32'h0);
        bus.wake_req[5] = 1'b0;
        run(3);
        check("wake_still_not_valid", 32'(bus.clock_valid[5]), 32'h0);
        step();
        check("wake_valid", 32'(bus.clock_valid[5]), 32'h1);

        // Drain abort: ack and wake_req together.
        bus.activity_detect = '1;
        bus.domain_enable[0] = 1'b0;
        step();
        check("abort_drain_req_set", 32'(bus.drain_req[0]), 32'h1);
        man_ack[0] = 1'b1;
        bus.drain_ack = bus.drain_ack | man_ack;
        bus.wake_req[0] = 1'b1;
        step();
        check("abort_drain_req_drop", 32'(bus.drain_req[0]), 32'h0);
        check("abort_clk_en", 32'(bus.clk_en[0]), 32'h1);
        bus.domain_enable[0] = 1'b1;
        bus.wake_req[0] = 1'b0;
        man_ack = '0;
        bus.drain_ack = '0;
        run(3);

        // Force-off: every domain drains and gates, wake_req ignored.
        power_mode = 2'd3;
        ack_mask = '1;
        run(6);
        bus.wake_req = '1;
        run(4);
        check("force_clk_en", 32'(bus.clk_en), 32'h0);
        check("force_gated_count", 32'(gated_count), 32'd16);
        check("force_estimate", 32'(power_savings_estimate), 32'd1600);
`ifdef CLOCK_GATE_STATS_EN
        stats_clear = 1'b1;
        step();
        stats_clear = 1'b0;
        run(2);
`endif
        power_mode = 2'd0;
        bus.wake_req = '0;
        step();
        check("rewake_clk_en", 32'(bus.clk_en), 32'h0000_FFFF);
        check("rewake_not_valid", 32'(bus.clock_valid), 32'h0);
        run(3);
        check("rewake_still_not_valid", 32'(bus.clock_valid), 32'h0);
        step();
        check("rewake_valid", 32'(bus.clock_valid), 32'h0000_FFFF);
        run(2);

        // Gate everything again, then reset from the all-off state.
        power_mode = 2'd3;
        run(6);
        check("final_all_off", 32'(bus.clk_en), 32'h0);
        do_reset();
        run(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, got stuck, expected completion");
        $fatal(1);
    end

endmodule
